mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_mem_pkg.sv | 35 +++
 rtl/arb_grant.sv | 40 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory arbiter:
// FSM states, owner encoding, size codes and the latched command bundle.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic mem_cmd_t pick_cmd(
    input owner_e   owner,
    input mem_cmd_t inst_cmd,
    input mem_cmd_t data_cmd
  );
    return (owner == OWNER_DATA) ? data_cmd : inst_cmd;
  endfunction

endpackage

// File: rtl/arb_grant.sv
// Grant selection between instruction and data requesters:
// data priority with starvation override, or round-robin on ties.
module arb_grant
  import cpu_mem_pkg::*;
#(
  parameter int DATA_PRIO  = 1,
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic          inst_req_i,
  input  logic          data_req_i,
  input  owner_e        last_i,
  input  logic [CW-1:0] starve_i,
  output logic          valid_o,
  output owner_e        owner_o
);

  logic starved;

  assign starved = (starve_i == CW'(STARVE_MAX));

  always_comb begin
    valid_o = inst_req_i | data_req_i;
    owner_o = OWNER_INST;
    unique case ({inst_req_i, data_req_i})
      2'b10: owner_o = OWNER_INST;
      2'b01: owner_o = OWNER_DATA;
      2'b11: begin
        if (DATA_PRIO != 0) begin
          owner_o = starved ? OWNER_INST : OWNER_DATA;
        end else begin
          // Tie goes to whichever side did not win last time.
          owner_o = (last_i == OWNER_INST) ? OWNER_DATA : OWNER_INST;
        end
      end
      default: owner_o = OWNER_INST;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter, one transaction in flight.
// IDLE grants and latches, REQ presents the command, RESP waits for data.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int DATA_PRIO  = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_q, last_d;
  logic [CW-1:0] starve_q, starve_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic          post_rst_q;

  logic          blk;
  logic          gnt_valid;
  owner_e        gnt_owner;
  mem_cmd_t      inst_cmd;
  mem_cmd_t      data_cmd;
  mem_cmd_t      mem_cmd;

  assign inst_cmd = '{
    wr:    inst_wr,
    size:  inst_size,
    addr:  inst_addr,
    wdata: inst_wdata
  };

  assign data_cmd = '{
    wr:    data_wr,
    size:  data_size,
    addr:  data_addr,
    wdata: data_wdata
  };

  // Outputs stay quiet during reset and for one cycle after it.
  assign blk = reset | post_rst_q;

  arb_grant #(
    .DATA_PRIO  (DATA_PRIO),
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_arb_grant (
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .last_i     (last_q),
    .starve_i   (starve_q),
    .valid_o    (gnt_valid),
    .owner_o    (gnt_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    starve_d     = starve_q;
    cmd_d        = cmd_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    if (!blk) begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            inst_addr_ok = (gnt_owner == OWNER_INST);
            data_addr_ok = (gnt_owner == OWNER_DATA);
            owner_d      = gnt_owner;
            last_d       = gnt_owner;
            cmd_d        = pick_cmd(gnt_owner, inst_cmd, data_cmd);
            state_d      = ST_REQ;
            if (gnt_owner == OWNER_INST || !inst_req) begin
              starve_d = '0;
            end else if (starve_q != CW'(STARVE_MAX)) begin
              starve_d = starve_q + CW'(1);
            end
          end
        end
        ST_REQ: begin
          mem_req = 1'b1;
          if (mem_addr_ok) begin
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_data_ok) begin
            inst_data_ok = (owner_q == OWNER_INST);
            data_data_ok = (owner_q == OWNER_DATA);
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign mem_cmd    = blk ? '0 : cmd_q;
  assign mem_wr     = mem_cmd.wr;
  assign mem_size   = mem_cmd.size;
  assign mem_addr   = mem_cmd.addr;
  assign mem_wdata  = mem_cmd.wdata;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_INST;
      last_q     <= OWNER_INST;
      starve_q   <= '0;
      cmd_q      <= '0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      starve_q   <= starve_d;
      cmd_q      <= cmd_d;
      post_rst_q <= 1'b0;
    end
  end

endmodule
